// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and request legality helper.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: extracts and extends load data, and merges
// store data into an existing word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic [XLEN-1:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      F3_W:    o_load_data = i_rdata;
      default: o_load_data = '0;
    endcase
  end

  always_comb begin
    o_store_word = i_rdata;
    case (i_funct3[1:0])
      2'b00: begin
        case (i_addr_lo)
          2'd0: o_store_word[7:0]   = i_wdata[7:0];
          2'd1: o_store_word[15:8]  = i_wdata[7:0];
          2'd2: o_store_word[23:16] = i_wdata[7:0];
          2'd3: o_store_word[31:24] = i_wdata[7:0];
          default: o_store_word = i_rdata;
        endcase
      end
      2'b01: begin
        if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
        else              o_store_word[15:0]  = i_wdata[15:0];
      end
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word-indexed memory port,
// sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned WIDX_W    = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  lsu_state_t        r_state;
  logic              r_req_ready;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [XLEN-1:0]   r_wdata;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_resp_rdata;
  logic              r_resp_err;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_misaligned;
  logic              w_range_err;
  logic              w_err;
  logic [XLEN-1:0]   w_widx;
  logic [XLEN-1:0]   w_load_data;
  logic [XLEN-1:0]   w_store_word;

  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_range_err  = |(req_addr >> (WIDX_W + 2));
  assign w_err        = !f3_legal(req_we, req_funct3) || w_misaligned || w_range_err;
  assign w_widx       = XLEN'(req_addr[WIDX_W+1:2]);

  lsu_lane_align u_lane_align (
    .i_funct3    (r_funct3),
    .i_addr_lo   (r_addr_lo),
    .i_rdata     (mem_rdata),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_store_word(w_store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_addr_lo    <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr_lo   <= req_addr[1:0];
            r_wdata     <= req_wdata;
            if (w_err) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (req_we && (req_funct3 == F3_W)) begin
              r_state     <= WR;
              r_mem_addr  <= w_widx;
              r_mem_wdata <= req_wdata;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= RD;
              r_mem_addr <= w_widx;
              r_mem_read <= 1'b1;
            end
          end
        end
        RD: begin
          r_mem_read <= 1'b0;
          // Sub-word stores merge into the word being read this cycle.
          if (r_we) begin
            r_state     <= WR;
            r_mem_wdata <= w_store_word;
            r_mem_write <= 1'b1;
          end else begin
            r_state      <= RESP;
            r_mem_addr   <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load_data;
          end
        end
        WR: begin
          r_state      <= RESP;
          r_mem_write  <= 1'b0;
          r_mem_addr   <= '0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        RESP: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  // Strobes are masked by reset so an abandoned access never touches memory.
  assign mem_read   = r_mem_read & ~reset;
  assign mem_write  = r_mem_write & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(1024), .WIDX_W(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
  end
  assign mem_rdata = mem_read ? mem[mem_addr[9:0]] : 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   overlap = 0;
  int   last_acc = 0;
  int   last_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (resp_valid) begin
      last_resp = cyc;
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
        if (e.lat >= 0) chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int el,
                       input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk({nm, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    last_acc = cyc;
    if (push) q.push_back('{rdata: er, err: ee, lat: el, acc: cyc, name: nm});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0;
    preload(10'd3, 32'h8899AABB);
    preload(10'd5, 32'h11223344);
    preload(10'd6, 32'h55667788);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    issue("lb_0e",  1'b0, 3'b000, 32'h0E, 32'h0, 32'hFFFFFF99, 1'b0, 2, 1'b1);
    issue("lhu_0c", 1'b0, 3'b101, 32'h0C, 32'h0, 32'h0000AABB, 1'b0, 2, 1'b1);
    issue("lh_0e",  1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 2, 1'b1);
    issue("lbu_0f", 1'b0, 3'b100, 32'h0F, 32'h0, 32'h00000088, 1'b0, 2, 1'b1);
    issue("lb_0c",  1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1'b1);
    wait_idle();

    wr0 = wr_cnt;
    issue("sb_15", 1'b1, 3'b000, 32'h15, 32'hFFFFFFA5, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    chk("sb_15_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("sb_15_mem", mem[5], 32'h1122A544);
    issue("sh_16", 1'b1, 3'b001, 32'h16, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    chk("sh_16_mem", mem[5], 32'hBEEFA544);

    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    chk("b2b_accept", 32'(last_acc), 32'(last_resp + 1));
    wait_idle();
    chk("sw_20_mem", mem[8], 32'hDEADBEEF);

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue("err_lw_22",   1'b0, 3'b010, 32'h22,   32'h0, 32'h0, 1'b1, -1, 1'b1);
    issue("err_sh_03",   1'b1, 3'b001, 32'h03,   32'h1234, 32'h0, 1'b1, -1, 1'b1);
    issue("err_sw_1000", 1'b1, 3'b010, 32'h1000, 32'h5555, 32'h0, 1'b1, -1, 1'b1);
    issue("err_s_f3_4",  1'b1, 3'b100, 32'h24,   32'h7777, 32'h0, 1'b1, -1, 1'b1);
    wait_idle();
    chk("err_no_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("err_no_writes", 32'(wr_cnt - wr0), 32'd0);

    issue("sb_rst", 1'b1, 3'b000, 32'h19, 32'h000000CC, 32'h0, 1'b0, 3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_rst_in_wr", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_mem", mem[6], 32'h55667788);

    chk("strobe_overlap", 32'(overlap), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core and drives the word-addressed data memory's Address/Write_data/MemRead/MemWrite/Read_data port.
- Converts RV32I byte addresses to word indices and performs byte/halfword/word loads with sign/zero extension.
- Implements sub-word stores as a read-modify-write on the 32-bit-wide memory.
- Sits between the execute stage and the data memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the attached memory (power of two).
- WIDX_W, 10, word-index width = log2(MEM_WORDS).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3; valid with resp_valid
- mem_addr  out  32  word index {zeros, byte_addr[WIDX_W+1:2]}
- mem_wdata  out  32  merged write word
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable; memory writes on the clk edge
- mem_rdata  in  32  memory read data; combinational while mem_read=1

Behaviour:
- Clock is clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, req_ready=1 (after reset deasserts), resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- States: IDLE, RD, WR, RESP.
- Accept: in IDLE with req_valid=1. Latch we, funct3, addr and wdata in that cycle. req_ready=0 in every other state.
- Validation at accept:
  - Error if: funct3 illegal for the op (stores allow only 000/001/010), halfword with addr[0]≠0, word with addr[1:0]≠0, or addr[31:WIDX_W+2]≠0.
  - On error go to RESP with err=1. No memory strobe is ever asserted.
- Load: IDLE→RD→RESP.
  - RD: mem_read=1. Capture mem_rdata at the RD clock edge.
  - Lane select by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend LB/LH; zero-extend LBU/LHU.
  - Accept-to-resp_valid latency = 2 cycles.
- SW: IDLE→WR→RESP.
  - WR: mem_write=1, mem_wdata=req_wdata.
  - Latency 2 cycles.
- SB/SH: IDLE→RD→WR→RESP.
  - RD captures the old word.
  - WR writes the old word with only the addressed byte/half replaced by wdata[7:0]/[15:0].
  - Latency 3 cycles. Exactly one mem_write cycle per store.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request may be accepted the cycle after RESP.
- mem_read and mem_write are never high together. Both are gated by !reset, so a reset asserted during RD/WR produces no memory write at that edge.
- Reset mid-operation: request abandoned, no resp_valid, state=IDLE the next cycle.
- mem_addr holds the latched word index throughout RD and WR, and is 0 in IDLE.
- req_valid asserted outside IDLE is ignored; the core must hold it until it sees req_ready.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state enum lsu_state_t
  - width constant XLEN=32
- One natural combinational sub-module: lsu_lane_align. It takes funct3, addr[1:0], rdata and wdata, and returns the extended load value and the merged store word. It is shared by the load and read-modify-write paths.

Test Plan:
- mem[3]=32'h8899AABB; LB addr 0x0E → resp_rdata=32'hFFFFFF99, err=0, resp_valid exactly 2 cycles after accept.
- Same word; LHU addr 0x0C → 32'h0000AABB. LH addr 0x0E → 32'hFFFF8899.
- mem[5]=32'h11223344; SB addr 0x15 wdata 0xFFFFFFA5 → one mem_write cycle, mem[5]=32'h1122A544, resp_valid 3 cycles after accept.
- SW addr 0x20 wdata 0xDEADBEEF then LW 0x20 → mem[8] and resp_rdata = 32'hDEADBEEF. Back-to-back requests are accepted the cycle after RESP.
- LW addr 0x22, SH addr 0x03, SW addr 0x1000, store funct3=100 → each gives resp_err=1, resp_rdata=0; mem_read and mem_write never asserted.
- Assert reset during the WR cycle of an SB → mem unchanged, no resp_valid, req_ready=1 the cycle after reset deasserts.
